// File: rtl/filter_fir_serial.sv
// Time-multiplexed FIR band filter: one MAC, TAPS enabled cycles per output sample, double-buffered coefficients.
// Optional FILTER_ROUND_EN: round half up before the output shift (default build truncates).
module filter_fir_serial #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 64,
  parameter int ADDR_W = $clog2(TAPS),
  parameter int ACC_W  = DATA_W + COEF_W + ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_enable,
  input  logic [DATA_W-1:0] i_signal_sample,
  input  logic              i_write_enable,
  input  logic              i_write_done,
  input  logic [ADDR_W-1:0] i_write_address,
  input  logic [COEF_W-1:0] i_coeffs_in,
  output logic [DATA_W-1:0] o_filtered_sample,
  output logic              o_valid,
  output logic              o_coeff_pending
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic [ADDR_W-1:0] LAST_PHASE = ADDR_W'(TAPS - 1);
  localparam logic [ADDR_W:0]   TAPS_LIM   = (ADDR_W + 1)'(TAPS);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};
`ifdef FILTER_ROUND_EN
  localparam logic signed [ACC_W-1:0] ROUND_K = ACC_W'(1) << (COEF_W - 2);
`endif

  logic [ADDR_W-1:0]        r_phase;
  logic signed [DATA_W-1:0] r_delay [TAPS];
  logic signed [COEF_W-1:0] r_coef  [2][TAPS];
  logic                     r_bank_sel;
  logic                     r_pending;
  logic signed [ACC_W-1:0]  r_acc;
  logic [DATA_W-1:0]        r_out;
  logic                     r_valid;
  logic                     r_wr_en;
  logic                     r_wr_done;
  logic [ADDR_W-1:0]        r_wr_addr;
  logic [COEF_W-1:0]        r_wr_data;

  logic                     w_frame_end;
  logic                     w_wr_ok;
  logic signed [PROD_W-1:0] w_tap_x;
  logic signed [PROD_W-1:0] w_tap_c;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_biased;
  logic signed [ACC_W-1:0]  w_shifted;
  logic [DATA_W-1:0]        w_sat;

  assign w_frame_end = clk_enable && (r_phase == LAST_PHASE);
  assign w_wr_ok     = r_wr_en && ({1'b0, r_wr_addr} < TAPS_LIM);

  // Bank select only changes on a frame edge, so a frame always reads one consistent bank.
  assign w_tap_x    = PROD_W'(r_delay[r_phase]);
  assign w_tap_c    = PROD_W'(r_coef[r_bank_sel][r_phase]);
  assign w_prod     = w_tap_x * w_tap_c;
  assign w_prod_ext = ACC_W'(w_prod);
  assign w_sum      = r_acc + w_prod_ext;

`ifdef FILTER_ROUND_EN
  assign w_biased = w_sum + ROUND_K;
`else
  assign w_biased = w_sum;
`endif

  assign w_shifted = w_biased >>> (COEF_W - 1);

  always_comb begin
    w_sat = w_shifted[DATA_W-1:0];
    if (w_shifted > SAT_MAX) begin
      w_sat = SAT_MAX[DATA_W-1:0];
    end else if (w_shifted < SAT_MIN) begin
      w_sat = SAT_MIN[DATA_W-1:0];
    end
  end

  // Coefficient write port is registered once and is independent of clk_enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_en   <= 1'b0;
      r_wr_done <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en   <= i_write_enable;
      r_wr_done <= i_write_done;
      r_wr_addr <= i_write_address;
      r_wr_data <= i_coeffs_in;
    end
  end

  // Writes always target the shadow bank; a pending swap is applied only at an enabled frame edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < TAPS; k++) begin
          r_coef[b][k] <= '0;
        end
      end
      r_bank_sel <= 1'b0;
      r_pending  <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_coef[~r_bank_sel][r_wr_addr] <= r_wr_data;
      end
      if (w_frame_end && r_pending) begin
        r_bank_sel <= ~r_bank_sel;
        r_pending  <= 1'b0;
      end else if (r_wr_done) begin
        r_pending <= 1'b1;
      end
    end
  end

  // MAC sequencing, output update and delay-line shift at the last phase of each frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase <= '0;
      r_acc   <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        r_delay[k] <= '0;
      end
    end else begin
      r_valid <= w_frame_end;
      if (clk_enable) begin
        if (r_phase == LAST_PHASE) begin
          r_phase    <= '0;
          r_acc      <= '0;
          r_out      <= w_sat;
          r_delay[0] <= i_signal_sample;
          for (int k = 1; k < TAPS; k++) begin
            r_delay[k] <= r_delay[k-1];
          end
        end else begin
          r_phase <= r_phase + ADDR_W'(1);
          r_acc   <= w_sum;
        end
      end
    end
  end

  assign o_filtered_sample = r_out;
  assign o_valid           = r_valid;
  assign o_coeff_pending   = r_pending;

endmodule

// File: tb/tb_filter_fir_serial.sv
// Directed bench for filter_fir_serial: an 8-tap and a 5-tap instance with hand-computed outputs.
// Expected values follow FILTER_ROUND_EN when the macro is defined for the build.
module tb_filter_fir_serial;

`ifdef FILTER_ROUND_EN
  localparam logic [15:0] HALF_Y = 16'h4000;
  localparam int          RND    = 1;
`else
  localparam logic [15:0] HALF_Y = 16'h3FFF;
  localparam int          RND    = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en8, we8, wd8, v8, p8;
  logic [2:0]  wa8;
  logic [15:0] wdata8, x8, y8;
  logic        en5, we5, wd5, v5, p5;
  logic [2:0]  wa5;
  logic [15:0] wdata5, x5, y5;

  int vectorsApplied = 0;
  int miscompares    = 0;
  int cycles;

  always #5 clk = ~clk;

  filter_fir_serial #(.TAPS(8)) dut8 (
    .clk(clk), .rst(rst), .clk_enable(en8), .i_signal_sample(x8),
    .i_write_enable(we8), .i_write_done(wd8), .i_write_address(wa8), .i_coeffs_in(wdata8),
    .o_filtered_sample(y8), .o_valid(v8), .o_coeff_pending(p8)
  );

  filter_fir_serial #(.TAPS(5)) dut5 (
    .clk(clk), .rst(rst), .clk_enable(en5), .i_signal_sample(x5),
    .i_write_enable(we5), .i_write_done(wd5), .i_write_address(wa5), .i_coeffs_in(wdata5),
    .o_filtered_sample(y5), .o_valid(v5), .o_coeff_pending(p5)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorsApplied++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle on the coefficient write port of the selected instance.
  task automatic applyStimulus(input int which, input logic we, input logic [2:0] addr,
                               input logic [15:0] data, input logic done);
    if (which == 8) begin
      we8 = we; wa8 = addr; wdata8 = data; wd8 = done;
    end else begin
      we5 = we; wa5 = addr; wdata5 = data; wd5 = done;
    end
    tick();
    we8 = 1'b0; wd8 = 1'b0; we5 = 1'b0; wd5 = 1'b0;
  endtask

  task automatic waitValid(input int which, output int n);
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 64) begin
      tick();
      n++;
      seen = (which == 8) ? (v8 === 1'b1) : (v5 === 1'b1);
    end
    if (!seen) checkOutput("validTimeout", 32'd0, 32'd1);
  endtask

  function automatic logic [15:0] stallExp(input int j);
    if (j >= 8) return 16'h0000;
    return 16'((j + 1) * 16'h0800 - 1 + RND);
  endfunction

  function automatic logic [15:0] tap5Exp(input int j);
    if (j == 0 || j >= 5) return 16'h0000;
    return 16'(j * 16'h1000 - 1 + RND);
  endfunction

  initial begin
    rst = 1'b0;
    en8 = 1'b1; we8 = 1'b0; wd8 = 1'b0; wa8 = '0; wdata8 = '0; x8 = '0;
    en5 = 1'b1; we5 = 1'b0; wd5 = 1'b0; wa5 = '0; wdata5 = '0; x5 = '0;
    repeat (3) tick();
    checkOutput("rstY8", 32'(y8), 32'h0);
    checkOutput("rstValid8", 32'(v8), 32'h0);
    checkOutput("rstPending8", 32'(p8), 32'h0);
    checkOutput("rstY5", 32'(y5), 32'h0);
    rst = 1'b1;

    $display("[TB] impulse through 0x4000 coefficients");
    for (int k = 0; k < 8; k++) applyStimulus(8, 1'b1, 3'(k), 16'h4000, k == 7);
    tick();
    checkOutput("validPulse", 32'(v8), 32'h0);
    checkOutput("pendingSet", 32'(p8), 32'h1);
    waitValid(8, cycles);
    checkOutput("pendingClear", 32'(p8), 32'h0);
    checkOutput("swapFrameY", 32'(y8), 32'h0);
    x8 = 16'h7FFF;
    waitValid(8, cycles);
    checkOutput("captureY", 32'(y8), 32'h0);
    x8 = 16'h0000;
    for (int j = 0; j < 9; j++) begin
      waitValid(8, cycles);
      checkOutput("impulsePeriod", 32'(cycles), 32'd8);
      checkOutput("impulseY", 32'(y8), (j < 8) ? 32'(HALF_Y) : 32'h0);
    end

    $display("[TB] bank swap requested mid-frame");
    x8 = 16'h1000;
    repeat (9) waitValid(8, cycles);
    checkOutput("steadyOld", 32'(y8), 32'h4000);
    for (int k = 0; k < 8; k++) applyStimulus(8, 1'b1, 3'(k), 16'h2000, 1'b0);
    checkOutput("noSwapYet", 32'(y8), 32'h4000);
    checkOutput("noSwapValid", 32'(v8), 32'h1);
    repeat (3) tick();
    applyStimulus(8, 1'b0, 3'd0, 16'h0000, 1'b1);
    tick();
    checkOutput("midPending", 32'(p8), 32'h1);
    waitValid(8, cycles);
    checkOutput("curFrameOld", 32'(y8), 32'h4000);
    checkOutput("edgeClears", 32'(p8), 32'h0);
    waitValid(8, cycles);
    checkOutput("nextFrameNew", 32'(y8), 32'h2000);

    $display("[TB] saturation");
    x8 = 16'h7FFF;
    for (int k = 0; k < 8; k++) applyStimulus(8, 1'b1, 3'(k), 16'h7FFF, k == 7);
    repeat (10) waitValid(8, cycles);
    checkOutput("satPos", 32'(y8), 32'h7FFF);
    x8 = 16'h8000;
    repeat (9) waitValid(8, cycles);
    checkOutput("satNeg", 32'(y8), 32'h8000);

    $display("[TB] stall inside a frame");
    x8 = 16'h0000;
    for (int k = 0; k < 8; k++) applyStimulus(8, 1'b1, 3'(k), 16'((k + 1) * 16'h0800), k == 7);
    repeat (10) waitValid(8, cycles);
    x8 = 16'h7FFF;
    waitValid(8, cycles);
    checkOutput("stallCapture", 32'(y8), 32'h0);
    x8 = 16'h0000;
    for (int j = 0; j < 9; j++) begin
      if (j == 2) begin
        repeat (3) tick();
        en8 = 1'b0;
        applyStimulus(8, 1'b1, 3'd0, 16'h7000, 1'b0);
        repeat (4) tick();
        checkOutput("stallValid", 32'(v8), 32'h0);
        checkOutput("stallHoldY", 32'(y8), 32'(stallExp(1)));
        checkOutput("stallNoPend", 32'(p8), 32'h0);
        en8 = 1'b1;
        waitValid(8, cycles);
        checkOutput("stallRemain", 32'(cycles), 32'd5);
      end else begin
        waitValid(8, cycles);
        checkOutput("stallPeriod", 32'(cycles), 32'd8);
      end
      checkOutput("stallY", 32'(y8), 32'(stallExp(j)));
    end

    $display("[TB] reset mid-frame");
    x8 = 16'h1234;
    repeat (2) waitValid(8, cycles);
    checkOutput("preResetY", 32'(y8), 32'h0123);
    applyStimulus(8, 1'b0, 3'd0, 16'h0000, 1'b1);
    tick();
    checkOutput("preResetPend", 32'(p8), 32'h1);
    tick();
    rst = 1'b0;
    #2;
    checkOutput("asyncY", 32'(y8), 32'h0);
    checkOutput("asyncValid", 32'(v8), 32'h0);
    checkOutput("asyncPend", 32'(p8), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    waitValid(8, cycles);
    checkOutput("postResetLat", 32'(cycles), 32'd8);
    checkOutput("postResetY", 32'(y8), 32'h0);

    $display("[TB] five-tap impulse");
    for (int k = 0; k < 5; k++) applyStimulus(5, 1'b1, 3'(k), 16'(k * 16'h1000), 1'b0);
    applyStimulus(5, 1'b1, 3'd5, 16'h7FFF, 1'b0);
    applyStimulus(5, 1'b1, 3'd7, 16'h7FFF, 1'b1);
    repeat (3) waitValid(5, cycles);
    checkOutput("tap5Pend", 32'(p5), 32'h0);
    x5 = 16'h7FFF;
    waitValid(5, cycles);
    checkOutput("tap5Capture", 32'(y5), 32'h0);
    x5 = 16'h0000;
    for (int j = 0; j < 6; j++) begin
      waitValid(5, cycles);
      checkOutput("tap5Period", 32'(cycles), 32'd5);
      checkOutput("tap5Y", 32'(y5), 32'(tap5Exp(j)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
